forwarding_unit: RTL and testbench

FORWARDING_UNIT -- requirements
Module: forwarding_unit

---
 rtl/fwd_pkg.sv | 31 +++
 rtl/fwd_match.sv | 22 ++
 rtl/forwarding_unit.sv | 146 ++++++++++++++
 tb/tb_forwarding_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding / load-use hazard unit.
//   SEL_*       : operand-mux select codes driven on ex_sel_a / ex_sel_b
//   MAX_ADDR_W  : storage width of register addresses inside the records;
//                 narrower REG_ADDR_W values are zero-extended on entry,
//                 so REG_ADDR_W must not exceed MAX_ADDR_W
//   pipe_rec_t  : producer record kept for the MEM and WB stages
//   ex_rec_t    : EX-stage record, producer fields plus consumer fields
package fwd_pkg;

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] SEL_EXMEM = 2'd1;
    localparam logic [1:0] SEL_MEMWB = 2'd2;

    localparam int MAX_ADDR_W = 8;

    typedef struct packed {
        logic                  valid;
        logic [MAX_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  load;
    } pipe_rec_t;

    typedef struct packed {
        pipe_rec_t             base;
        logic [MAX_ADDR_W-1:0] rs1;
        logic [MAX_ADDR_W-1:0] rs2;
        logic                  use_rs1;
        logic                  use_rs2;
    } ex_rec_t;

endpackage

// File: rtl/fwd_match.sv
// Single source/producer comparator.
//   rs        in  : source register address of the consumer
//   use_rs    in  : consumer really reads rs (already gated by consumer valid)
//   rec_valid in  : producer record valid
//   rec_qual  in  : producer qualifier (reg_write for forwarding, load for stall)
//   rec_rd    in  : producer destination address
//   hit       out : consumer depends on this producer
// x0 never matches: it is hardwired to zero and has no producer.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [MAX_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  logic                  rec_valid,
    input  logic                  rec_qual,
    input  logic [MAX_ADDR_W-1:0] rec_rd,
    output logic                  hit
);

    assign hit = use_rs & rec_valid & rec_qual & (rec_rd == rs) & (rs != '0);

endmodule

// File: rtl/forwarding_unit.sv
// Operand forwarding and load-use stall detection for a 5-stage pipeline.
// Tracks EX, MEM and WB instruction records and produces EX operand-mux
// selects (youngest producer wins) plus a one-cycle load-use stall.
//   clk, arst_n              : clock, asynchronous active-low reset
//   pipe_en                  : pipeline advance enable (0 = frozen)
//   flush                    : drop the instruction leaving ID
//   id_valid/reg_write/mem_read, id_use_rs1/rs2, id_rs1/rs2/rd : ID instruction
//   ex_sel_a, ex_sel_b       : operand selects (SEL_RF / SEL_EXMEM / SEL_MEMWB)
//   stall                    : hold PC and IF/ID, bubble into EX
// Optional macro FORWARDING_UNIT_PERF_EN adds saturating stall_cnt / fwd_cnt.
module forwarding_unit
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  pipe_en,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    output logic [1:0]            ex_sel_a,
    output logic [1:0]            ex_sel_b,
    output logic                  stall
`ifdef FORWARDING_UNIT_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      fwd_cnt
`endif
);

    logic [MAX_ADDR_W-1:0] id_rs1_x;
    logic [MAX_ADDR_W-1:0] id_rs2_x;
    pipe_rec_t             id_base;

    ex_rec_t               ex_q;
    pipe_rec_t             mem_q;
    pipe_rec_t             wb_q;

    logic hit_mem_a, hit_wb_a, hit_mem_b, hit_wb_b;
    logic hit_ld_1, hit_ld_2;
    logic ex_use_a, ex_use_b;

    assign id_rs1_x = MAX_ADDR_W'(id_rs1);
    assign id_rs2_x = MAX_ADDR_W'(id_rs2);

    assign id_base = '{valid:     id_valid,
                       rd:        MAX_ADDR_W'(id_rd),
                       reg_write: id_reg_write,
                       load:      id_mem_read};

    // Record pipeline. A flush still kills the EX entry while frozen.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (pipe_en) begin
            ex_q.base       <= id_base;
            ex_q.base.valid <= id_valid & ~stall & ~flush;
            ex_q.rs1        <= id_rs1_x;
            ex_q.rs2        <= id_rs2_x;
            ex_q.use_rs1    <= id_use_rs1;
            ex_q.use_rs2    <= id_use_rs2;
            mem_q           <= ex_q.base;
            wb_q            <= mem_q;
        end else if (flush) begin
            ex_q.base.valid <= 1'b0;
        end
    end

    // A bubble in EX consumes nothing, so it must not request forwarding.
    assign ex_use_a = ex_q.use_rs1 & ex_q.base.valid;
    assign ex_use_b = ex_q.use_rs2 & ex_q.base.valid;

    fwd_match u_mem_a (
        .rs(ex_q.rs1), .use_rs(ex_use_a),
        .rec_valid(mem_q.valid), .rec_qual(mem_q.reg_write), .rec_rd(mem_q.rd),
        .hit(hit_mem_a)
    );

    fwd_match u_wb_a (
        .rs(ex_q.rs1), .use_rs(ex_use_a),
        .rec_valid(wb_q.valid), .rec_qual(wb_q.reg_write), .rec_rd(wb_q.rd),
        .hit(hit_wb_a)
    );

    fwd_match u_mem_b (
        .rs(ex_q.rs2), .use_rs(ex_use_b),
        .rec_valid(mem_q.valid), .rec_qual(mem_q.reg_write), .rec_rd(mem_q.rd),
        .hit(hit_mem_b)
    );

    fwd_match u_wb_b (
        .rs(ex_q.rs2), .use_rs(ex_use_b),
        .rec_valid(wb_q.valid), .rec_qual(wb_q.reg_write), .rec_rd(wb_q.rd),
        .hit(hit_wb_b)
    );

    // Load-use: the ID consumer against a load sitting in EX.
    fwd_match u_ld_1 (
        .rs(id_rs1_x), .use_rs(id_use_rs1 & id_valid),
        .rec_valid(ex_q.base.valid), .rec_qual(ex_q.base.load), .rec_rd(ex_q.base.rd),
        .hit(hit_ld_1)
    );

    fwd_match u_ld_2 (
        .rs(id_rs2_x), .use_rs(id_use_rs2 & id_valid),
        .rec_valid(ex_q.base.valid), .rec_qual(ex_q.base.load), .rec_rd(ex_q.base.rd),
        .hit(hit_ld_2)
    );

    assign ex_sel_a = hit_mem_a ? SEL_EXMEM : (hit_wb_a ? SEL_MEMWB : SEL_RF);
    assign ex_sel_b = hit_mem_b ? SEL_EXMEM : (hit_wb_b ? SEL_MEMWB : SEL_RF);
    assign stall    = hit_ld_1 | hit_ld_2;

    // Load flags of the MEM/WB records are kept for visibility only.
    logic unused_rec;
    assign unused_rec = mem_q.load ^ wb_q.load;

`ifdef FORWARDING_UNIT_PERF_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else if (pipe_en) begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (((ex_sel_a != SEL_RF) || (ex_sel_b != SEL_RF)) && (fwd_cnt != '1)) begin
                fwd_cnt <= fwd_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_forwarding_unit.sv
module tb_forwarding_unit;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       pipe_en;
    logic       flush;
    logic       id_valid, id_reg_write, id_mem_read, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] ex_sel_a, ex_sel_b;
    logic       stall;
`ifdef FORWARDING_UNIT_PERF_EN
    logic [31:0] stall_cnt, fwd_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    forwarding_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .pipe_en(pipe_en), .flush(flush),
        .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b), .stall(stall)
`ifdef FORWARDING_UNIT_PERF_EN
        , .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
`endif
    );

    task automatic set_id(input logic v, input logic rw, input logic ld, input logic u1,
                          input logic u2, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] d);
        id_valid = v; id_reg_write = rw; id_mem_read = ld;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rs1 = r1; id_rs2 = r2; id_rd = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic rw, input logic ld, input logic u1,
                         input logic u2, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] d);
        set_id(v, rw, ld, u1, u2, r1, r2, d);
        step();
    endtask

    task automatic drain;
        repeat (3) issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset;
        arst_n = 1'b0; pipe_en = 1'b1; flush = 1'b0;
        set_id(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 5'd7, 5'd7);
        #1;
        n_cmp++; if (ex_sel_a !== 2'd0) begin n_bad++; $display("FAIL reset_sel_a got %0d want 0", ex_sel_a); end
        n_cmp++; if (ex_sel_b !== 2'd0) begin n_bad++; $display("FAIL reset_sel_b got %0d want 0", ex_sel_b); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall); end
`ifdef FORWARDING_UNIT_PERF_EN
        n_cmp++; if (fwd_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_fwd_cnt got %0d want 0", fwd_cnt); end
        n_cmp++; if (stall_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
        set_id(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (2) step();
        arst_n = 1'b1;
        step();
        n_cmp++; if (ex_sel_a !== 2'd0 || ex_sel_b !== 2'd0 || stall !== 1'b0) begin
            n_bad++; $display("FAIL post_reset got a=%0d b=%0d stall=%0b want 0/0/0", ex_sel_a, ex_sel_b, stall);
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);   // add x3,x1,x2
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd5, 5'd4);   // add x4,x3,x5
        n_cmp++; if (ex_sel_a !== 2'd1) begin n_bad++; $display("FAIL b2b_sel_a got %0d want 1", ex_sel_a); end
        n_cmp++; if (ex_sel_b !== 2'd0) begin n_bad++; $display("FAIL b2b_sel_b got %0d want 0", ex_sel_b); end
        drain();
    endtask

    task automatic test_load_use;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd7);   // lw x7,0(x2)
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 5'd8);  // add x8,x7,x1
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall got %0b want 1", stall); end
        step();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_release got %0b want 0", stall); end
        n_cmp++; if (ex_sel_a !== 2'd0) begin n_bad++; $display("FAIL lu_bubble_sel_a got %0d want 0", ex_sel_a); end
        step();
        n_cmp++; if (ex_sel_a !== 2'd2) begin n_bad++; $display("FAIL lu_sel_a got %0d want 2", ex_sel_a); end
        n_cmp++; if (ex_sel_b !== 2'd0) begin n_bad++; $display("FAIL lu_sel_b got %0d want 0", ex_sel_b); end
        drain();
    endtask

`ifdef FORWARDING_UNIT_PERF_EN
    task automatic test_perf;
        n_cmp++; if (fwd_cnt !== 32'd2) begin n_bad++; $display("FAIL perf_fwd_cnt got %0d want 2", fwd_cnt); end
        n_cmp++; if (stall_cnt !== 32'd1) begin n_bad++; $display("FAIL perf_stall_cnt got %0d want 1", stall_cnt); end
    endtask
`endif

    task automatic test_wb_priority;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);   // add x3
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);   // nop
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd6);   // sub x6,x3,x3
        n_cmp++; if (ex_sel_a !== 2'd2) begin n_bad++; $display("FAIL wb_sel_a got %0d want 2", ex_sel_a); end
        n_cmp++; if (ex_sel_b !== 2'd2) begin n_bad++; $display("FAIL wb_sel_b got %0d want 2", ex_sel_b); end
        drain();
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);   // add x3
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);   // add x3 again
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd6);   // sub x6,x3,x3
        n_cmp++; if (ex_sel_a !== 2'd1) begin n_bad++; $display("FAIL prio_sel_a got %0d want 1", ex_sel_a); end
        n_cmp++; if (ex_sel_b !== 2'd1) begin n_bad++; $display("FAIL prio_sel_b got %0d want 1", ex_sel_b); end
        drain();
    endtask

    task automatic test_x0;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd0);   // add x0,x1,x2
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd9);   // add x9,x0,x0
        n_cmp++; if (ex_sel_a !== 2'd0 || ex_sel_b !== 2'd0) begin
            n_bad++; $display("FAIL x0_mem got a=%0d b=%0d want 0/0", ex_sel_a, ex_sel_b);
        end
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd10);  // add x10,x0,x0
        n_cmp++; if (ex_sel_a !== 2'd0 || ex_sel_b !== 2'd0) begin
            n_bad++; $display("FAIL x0_wb got a=%0d b=%0d want 0/0", ex_sel_a, ex_sel_b);
        end
        drain();
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0);   // lw x0
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 5'd0, 5'd11); // add x11,x0,x0
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_lw_stall got %0b want 0", stall); end
        step();
        n_cmp++; if (ex_sel_a !== 2'd0 || ex_sel_b !== 2'd0) begin
            n_bad++; $display("FAIL x0_lw_sel got a=%0d b=%0d want 0/0", ex_sel_a, ex_sel_b);
        end
        drain();
    endtask

    task automatic test_flush;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);   // add x3
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd5, 5'd4);  // add x4,x3,x5 (flushed)
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (ex_sel_a !== 2'd0) begin n_bad++; $display("FAIL flush_sel_a got %0d want 0", ex_sel_a); end
        drain();
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd7);   // lw x7
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 5'd8);  // add x8,x7,x1
        flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL flush_lu_stall got %0b want 1", stall); end
        step();
        flush = 1'b0;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_lu_cleared got %0b want 0", stall); end
        drain();
    endtask

    task automatic test_freeze;
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);   // add x3
        issue(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 5'd5, 5'd4);   // add x4,x3,x5
        pipe_en = 1'b0;
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 5'd4, 5'd12);
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (ex_sel_a !== 2'd1 || ex_sel_b !== 2'd0) begin
                n_bad++; $display("FAIL freeze_%0d got a=%0d b=%0d want 1/0", i, ex_sel_a, ex_sel_b);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (ex_sel_a !== 2'd0) begin n_bad++; $display("FAIL freeze_flush_sel_a got %0d want 0", ex_sel_a); end
        pipe_en = 1'b1;
        drain();
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd7);   // lw x7
        pipe_en = 1'b0;
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 5'd8);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL frozen_stall got %0b want 1", stall); end
        step();
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL frozen_stall_hold got %0b want 1", stall); end
        pipe_en = 1'b1;
        step();
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL unfrozen_stall got %0b want 0", stall); end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd0, 5'd7);   // lw x7
        set_id(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 5'd1, 5'd8);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_pre_stall got %0b want 1", stall); end
        arst_n = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mid_reset_stall got %0b want 0", stall); end
        #1;
        arst_n = 1'b1;
        step();
        n_cmp++; if (stall !== 1'b0 || ex_sel_a !== 2'd0 || ex_sel_b !== 2'd0) begin
            n_bad++; $display("FAIL mid_after got stall=%0b a=%0d b=%0d want 0/0/0", stall, ex_sel_a, ex_sel_b);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
`ifdef FORWARDING_UNIT_PERF_EN
        test_perf();
`endif
        test_wb_priority();
        test_x0();
        test_flush();
        test_freeze();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
